// File: rtl/rom_scan_pkg.sv
// rom_scan_pkg: shared types, default sizes and address helper for rom_scan_ctrl.
package rom_scan_pkg;

    localparam int DATA_W    = 8;
    localparam int NUM_WORDS = 8;
    localparam int IDX_W     = $clog2(NUM_WORDS);

    typedef enum logic [1:0] {IDLE, REQ, CAP, OUT} state_t;

    function automatic logic [NUM_WORDS-1:0] onehot(input logic [IDX_W-1:0] idx);
        return NUM_WORDS'(1) << idx;
    endfunction

endpackage

// File: rtl/rom_scan_ctrl.sv
// rom_scan_ctrl: scans a one-hot-addressed 1-cycle ROM and streams each word out with index/last.
// Optional running XOR of the scan enabled by defining ROM_SCAN_CHECKSUM_EN.
module rom_scan_ctrl #(
    parameter int DATA_W    = rom_scan_pkg::DATA_W,
    parameter int NUM_WORDS = rom_scan_pkg::NUM_WORDS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         rom_en,
    output logic [NUM_WORDS-1:0]         rom_addr,
    input  logic [DATA_W-1:0]            rom_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(NUM_WORDS)-1:0] out_idx,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done
`ifdef ROM_SCAN_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]            checksum
`endif
);
    import rom_scan_pkg::*;

    localparam int IW = $clog2(NUM_WORDS);

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d, out_idx_q, out_idx_d;
    logic                rom_en_q, rom_en_d, out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d, busy_q, busy_d, done_q, done_d;
    logic [NUM_WORDS-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d, cs_q, cs_d;

    function automatic logic [NUM_WORDS-1:0] addr_of(input logic [IW-1:0] i);
        return NUM_WORDS'(onehot(IDX_W'(i)));
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rom_en_d    = 1'b0;
        rom_addr_d  = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        cs_d        = cs_q;
        case (state_q)
            // done_q blocks a start landing on the done pulse, so it is not accepted early
            IDLE: if (start && !done_q) begin
                state_d    = REQ;
                idx_d      = '0;
                rom_en_d   = 1'b1;
                rom_addr_d = addr_of('0);
                cs_d       = '0;
            end
            REQ: state_d = CAP;
            CAP: begin
                out_data_d  = rom_data;
                out_idx_d   = idx_q;
                out_last_d  = (idx_q == IW'(NUM_WORDS - 1));
                out_valid_d = 1'b1;
                cs_d        = cs_q ^ rom_data;
                state_d     = OUT;
            end
            OUT: if (out_ready) begin
                out_valid_d = 1'b0;
                if (out_last_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d      = idx_q + IW'(1);
                    state_d    = REQ;
                    rom_en_d   = 1'b1;
                    rom_addr_d = addr_of(idx_q + IW'(1));
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cs_q        <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rom_en_q    <= rom_en_d;
            rom_addr_q  <= rom_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cs_q        <= cs_d;
        end
    end

    assign rom_en    = rom_en_q;
    assign rom_addr  = rom_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef ROM_SCAN_CHECKSUM_EN
    assign checksum  = cs_q;
`else
    logic unused_cs;
    assign unused_cs = ^cs_q;
`endif

endmodule

// File: tb/tb_rom_scan_ctrl.sv
// tb_rom_scan_ctrl: scoreboard bench for rom_scan_ctrl against a 1-cycle one-hot ROM model.
module tb_rom_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       out_ready = 1'b0;
    logic       rom_en, out_valid, out_last, busy, done;
    logic [7:0] rom_addr, out_data;
    logic [7:0] rom_data = 8'h00;
    logic [2:0] out_idx;
    logic [7:0] checksum;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] idx;
        logic       last;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] addr_log[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         done_cnt = 0;
    logic       prev_en = 1'b0;

    always #5 clk = ~clk;

    rom_scan_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
`ifdef ROM_SCAN_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

`ifndef ROM_SCAN_CHECKSUM_EN
    assign checksum = 8'h88;
`endif

    function automatic logic [7:0] word(input int i);
        return 8'(8'h11 * (i + 1));
    endfunction

    always @(posedge clk)
        if (rom_en)
            for (int i = 0; i < 8; i++)
                if (rom_addr[i]) rom_data <= word(i);

    always @(negedge clk) begin
        if (!rst_n) prev_en = 1'b0;
        else begin
            n_cmp++;
            if (!$onehot0(rom_addr)) begin
                n_err++; $display("FAIL onehot0: rom_addr=%h", rom_addr);
            end
            n_cmp++;
            if (!rom_en && rom_addr != 8'h00) begin
                n_err++; $display("FAIL addr_without_en: rom_addr=%h required 00", rom_addr);
            end
            n_cmp++;
            if (rom_en && prev_en) begin
                n_err++; $display("FAIL en_two_cycles: rom_en high on consecutive cycles, addr=%h", rom_addr);
            end
            prev_en = rom_en;
            if (rom_en) addr_log.push_back(rom_addr);
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL unexpected_word: data=%h idx=%0d with empty scoreboard", out_data, out_idx);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (out_data !== e.data || out_idx !== e.idx || out_last !== e.last) begin
                        n_err++;
                        $display("FAIL word: got data=%h idx=%0d last=%b required data=%h idx=%0d last=%b",
                                 out_data, out_idx, out_last, e.data, e.idx, e.last);
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_scan;
        for (int i = 0; i < 8; i++) sb.push_back('{word(i), 3'(i), i == 7});
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic check_scan_end(input string name);
        n_cmp++;
        if (addr_log.size() != 8) begin
            n_err++; $display("FAIL %s_reads: got %0d rom reads required 8", name, addr_log.size());
        end else
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (addr_log[i] !== 8'(1 << i)) begin
                    n_err++; $display("FAIL %s_addr%0d: got %h required %h", name, i, addr_log[i], 8'(1 << i));
                end
            end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL %s_sb_left: %0d words never delivered", name, sb.size());
        end
        n_cmp++;
        if (checksum !== 8'h88) begin
            n_err++; $display("FAIL %s_checksum: got %h required 88", name, checksum);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({rom_en, rom_addr, out_valid, busy, done, out_data, out_idx, out_last} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: en=%b addr=%h valid=%b busy=%b done=%b data=%h idx=%0d last=%b required all 0",
                     rom_en, rom_addr, out_valid, busy, done, out_data, out_idx, out_last);
        end
`ifdef ROM_SCAN_CHECKSUM_EN
        n_cmp++;
        if (checksum !== 8'h00) begin
            n_err++; $display("FAIL reset_checksum: got %h required 00", checksum);
        end
`endif
        start = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_scan;
        int n;
        out_ready = 1'b1;
        addr_log.delete();
        done_cnt = 0;
        push_scan();
        pulse_start();
        n_cmp++;
        if (rom_en !== 1'b1 || rom_addr !== 8'h01 || busy !== 1'b1) begin
            n_err++; $display("FAIL first_req: en=%b addr=%h busy=%b required 1/01/1", rom_en, rom_addr, busy);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || rom_en !== 1'b0) begin
            n_err++; $display("FAIL cap_cycle: valid=%b en=%b required 0/0", out_valid, rom_en);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            n_err++; $display("FAIL latency: valid=%b data=%h required 1/11", out_valid, out_data);
        end
`ifdef ROM_SCAN_CHECKSUM_EN
        n_cmp++;
        if (checksum !== 8'h11) begin
            n_err++; $display("FAIL checksum_first: got %h required 11", checksum);
        end
`endif
        wait_done(n);
        n = n + 2;
        n_cmp++;
        if (n != 24) begin
            n_err++; $display("FAIL scan_cycles: done after %0d cycles required 24", n);
        end
        tick();
        n_cmp++;
        if (done_cnt != 1 || done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL done_pulse: count=%0d done=%b busy=%b required 1/0/0", done_cnt, done, busy);
        end
        check_scan_end("full");
    endtask

    task automatic test_backpressure;
        int n;
        out_ready = 1'b0;
        addr_log.delete();
        push_scan();
        pulse_start();
        for (int w = 0; w < 8; w++) begin
            for (int t = 0; t < 10 && !out_valid; t++) tick();
            n_cmp++;
            if (!out_valid) begin
                n_err++; $display("FAIL bp_timeout: word %0d never valid", w);
                break;
            end
            if (out_idx == 3'd3)
                for (int h = 0; h < 5; h++) begin
                    tick();
                    n_cmp++;
                    if (out_valid !== 1'b1 || out_data !== 8'h44 || out_idx !== 3'd3 || rom_en !== 1'b0) begin
                        n_err++;
                        $display("FAIL bp_hold%0d: valid=%b data=%h idx=%0d en=%b required 1/44/3/0",
                                 h, out_valid, out_data, out_idx, rom_en);
                    end
                end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            if (w == 3) begin
                n_cmp++;
                if (rom_en !== 1'b1 || rom_addr !== 8'h10) begin
                    n_err++; $display("FAIL bp_next_addr: en=%b addr=%h required 1/10", rom_en, rom_addr);
                end
            end
        end
        wait_done(n);
        tick();
        check_scan_end("bp");
    endtask

    task automatic test_start_busy;
        int n;
        out_ready = 1'b1;
        addr_log.delete();
        push_scan();
        pulse_start();
        for (int t = 0; t < 20 && !(rom_en && rom_addr == 8'h04); t++) tick();
        n_cmp++;
        if (rom_addr !== 8'h04) begin
            n_err++; $display("FAIL busy_reach_idx2: addr=%h required 04", rom_addr);
        end
        pulse_start();
        wait_done(n);
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++; $display("FAIL busy_done_timeout: done=%b required 1", done);
        end
        pulse_start();
        n_cmp++;
        if (busy !== 1'b0 || rom_en !== 1'b0) begin
            n_err++; $display("FAIL start_on_done: busy=%b en=%b required 0/0", busy, rom_en);
        end
        tick();
        check_scan_end("busy");
        addr_log.delete();
        push_scan();
        pulse_start();
        n_cmp++;
        if (rom_addr !== 8'h01) begin
            n_err++; $display("FAIL rescan_addr: got %h required 01", rom_addr);
        end
        wait_done(n);
        tick();
        check_scan_end("rescan");
    endtask

    task automatic test_async_reset;
        int n;
        out_ready = 1'b1;
        addr_log.delete();
        push_scan();
        pulse_start();
        for (int t = 0; t < 30 && !(out_valid && out_idx == 3'd4); t++) tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rom_en, rom_addr, out_valid, busy, done, out_data, out_idx, out_last} !== '0) begin
            n_err++;
            $display("FAIL async_reset: en=%b addr=%h valid=%b busy=%b done=%b data=%h idx=%0d last=%b required all 0",
                     rom_en, rom_addr, out_valid, busy, done, out_data, out_idx, out_last);
        end
`ifdef ROM_SCAN_CHECKSUM_EN
        n_cmp++;
        if (checksum !== 8'h00) begin
            n_err++; $display("FAIL async_reset_checksum: got %h required 00", checksum);
        end
`endif
        sb.delete();
        #2 rst_n = 1'b1;
        tick();
        addr_log.delete();
        push_scan();
        pulse_start();
        n_cmp++;
        if (rom_addr !== 8'h01) begin
            n_err++; $display("FAIL post_reset_addr: got %h required 01", rom_addr);
        end
        wait_done(n);
        tick();
        check_scan_end("post_reset");
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_backpressure();
        test_start_busy();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
